time_set_controller: RTL
========================

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 SHALL have parameter PROP_CYCLES, default 4: number of clk cycles clock_propagate is held high after a clock-set confirm (legal 1..255).
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports named as follows:
- clk  input  1  50 MHz system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_mode  input  1  single-cycle, debounced pulse; cycles the operating mode.
- btn_next  input  1  single-cycle pulse; selects the next digit to edit.
- btn_inc  input  1  single-cycle pulse; increments the selected digit (RUN: toggles alarm arm).
- btn_confirm  input  1  single-cycle pulse; commits an edit (RUN: dismisses alarm).
- current_time  input  24  running BCD time hh:mm:ss from the clock datapath, 4 bits per digit.
- intended_time  output  24  BCD time to load into the clock datapath.
- clock_propagate  output  1  load strobe to the clock datapath.
- alarm_time  output  24  stored BCD alarm time.
- alarm_armed  output  1  alarm enabled.
- alarm_ring  output  1  alarm active.
- edit_buffer  output  24  BCD value being edited, for display.
- edit_digit  output  3  selected digit: 5=hour tens ... 0=second units.
- mode  output  2  0=RUN, 1=EDIT_CLOCK, 2=EDIT_ALARM, 3=PROPAGATE.

Function
REQ-003 SHALL apply button priority when pulses coincide: mode > confirm > next > inc; only the highest-priority pulse acts in a cycle.
REQ-004 SHALL handle btn_mode as follows:
- RUN -> EDIT_CLOCK: edit_buffer <= current_time, edit_digit <= 5.
- EDIT_CLOCK -> EDIT_ALARM: edit_buffer <= alarm_time, edit_digit <= 5.
- EDIT_ALARM -> RUN: edit discarded.
- PROPAGATE: ignored.
REQ-005 SHALL, on btn_next in either EDIT state, decrement edit_digit, wrapping 0 -> 5.
REQ-006 SHALL, on btn_inc in either EDIT state, increment the selected digit with these wrap limits:
- digit 5: 0..2.
- digit 4: 0..9 if digit5<2, else 0..3.
- digits 3 and 1: 0..5.
- digits 2 and 0: 0..9.
- Each digit wraps to 0 above its limit.
REQ-007 SHALL clamp digit 4 to 3 in the same cycle that digit 5 becomes 2 while digit 4 > 3, so edit_buffer never holds an hour above 23.
REQ-008 SHALL, on btn_confirm in EDIT_CLOCK, load intended_time <= edit_buffer, enter PROPAGATE, and assert clock_propagate starting the next cycle.
REQ-009 SHALL hold clock_propagate high for exactly PROP_CYCLES consecutive cycles, then deassert it and return to RUN; all buttons are ignored during PROPAGATE.
REQ-010 SHALL, on btn_confirm in EDIT_ALARM, load alarm_time <= edit_buffer, set alarm_armed <= 1, and return to RUN.
REQ-011 SHALL, on btn_inc in RUN, toggle alarm_armed; disarming also clears alarm_ring in the same cycle.
REQ-012 SHALL set alarm_ring only when all of the following hold:
- mode is RUN;
- alarm_armed = 1;
- current_time == alarm_time;
- current_time differs from its value registered the previous cycle (match on entry only, one trigger per second).
REQ-013 SHALL clear alarm_ring on btn_confirm in RUN (consumed, no other effect) and on any transition out of RUN.
REQ-014 SHALL not modify intended_time, alarm_time or alarm_armed while editing until the corresponding confirm.
REQ-015 SHALL output edit_buffer = current_time whenever mode is RUN.

Reset
REQ-016 SHALL, while rst_n is low, asynchronously force:
- mode = RUN, edit_digit = 5;
- intended_time = 0, alarm_time = 0, edit_buffer = 0;
- clock_propagate = 0, alarm_armed = 0, alarm_ring = 0;
- the propagate counter to 0.
REQ-017 SHALL, on reset asserted mid-PROPAGATE, drop clock_propagate immediately and not resume the strobe after reset releases.

Verification
REQ-018 Clock set: current_time=0x123456; btn_mode; btn_next; btn_inc x2; btn_confirm -> intended_time=0x143456, clock_propagate high exactly 4 cycles, then mode=RUN.
REQ-019 Hour clamp: edit_buffer=0x190000, digit 5 selected, btn_inc -> 0x230000; btn_inc again -> 0x030000.
REQ-020 Alarm: set alarm_time 0x070000 via EDIT_ALARM, then current_time steps 0x065959 -> 0x070000 -> alarm_ring=1 one cycle later; btn_confirm -> alarm_ring=0, with no re-trigger while current_time holds 0x070000.
REQ-021 Priority: btn_mode and btn_confirm in the same cycle in EDIT_CLOCK -> mode=EDIT_ALARM, intended_time unchanged, no clock_propagate.
REQ-022 Reset mid-operation: rst_n low in cycle 2 of PROPAGATE -> clock_propagate=0 asynchronously, all outputs at reset values, mode=RUN after release.
REQ-023 Discard: from EDIT_CLOCK, btn_inc on digit 0, then btn_mode twice -> mode=RUN, intended_time and alarm_time unchanged.

Source files
------------

// File: rtl/time_set_controller.sv
// Time/alarm setting controller: button-driven BCD editor that loads the clock
// datapath through a timed propagate strobe and manages a single daily alarm.
module time_set_controller #(
  parameter int PROP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        btn_confirm,
  input  logic [23:0] current_time,
  output logic [23:0] intended_time,
  output logic        clock_propagate,
  output logic [23:0] alarm_time,
  output logic        alarm_armed,
  output logic        alarm_ring,
  output logic [23:0] edit_buffer,
  output logic [2:0]  edit_digit,
  output logic [1:0]  mode
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    EDIT_CLOCK = 2'd1,
    EDIT_ALARM = 2'd2,
    PROPAGATE  = 2'd3
  } mode_t;

  mode_t       state, state_next;
  logic [23:0] edit_q, edit_next;
  logic [23:0] intended_next, alarm_next;
  logic [2:0]  digit_next;
  logic        armed_next, ring_next, prop_next;
  logic [7:0]  cnt, cnt_next;
  logic [23:0] prev_time;

  // Increment one BCD digit with its wrap limit; raising the hour tens to 2
  // pulls the hour units down to 3 so the buffer never shows an hour above 23.
  function automatic logic [23:0] inc_digit(input logic [23:0] v, input logic [2:0] d);
    logic [23:0] r;
    logic [3:0]  nib;
    logic [3:0]  lim;
    r = v;
    for (int i = 0; i < 6; i++) begin
      if (d == 3'(i)) begin
        nib = v[i*4 +: 4];
        case (i)
          5:       lim = 4'd2;
          4:       lim = (v[23:20] < 4'd2) ? 4'd9 : 4'd3;
          3, 1:    lim = 4'd5;
          default: lim = 4'd9;
        endcase
        r[i*4 +: 4] = (nib >= lim) ? 4'd0 : nib + 4'd1;
      end
    end
    if (d == 3'd5 && r[23:20] == 4'd2 && r[19:16] > 4'd3)
      r[19:16] = 4'd3;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      edit_q          <= '0;
      edit_digit      <= 3'd5;
      intended_time   <= '0;
      alarm_time      <= '0;
      alarm_armed     <= 1'b0;
      alarm_ring      <= 1'b0;
      clock_propagate <= 1'b0;
      cnt             <= '0;
    end else begin
      state           <= state_next;
      edit_q          <= edit_next;
      edit_digit      <= digit_next;
      intended_time   <= intended_next;
      alarm_time      <= alarm_next;
      alarm_armed     <= armed_next;
      alarm_ring      <= ring_next;
      clock_propagate <= prop_next;
      cnt             <= cnt_next;
    end
  end

  // Previous-cycle time, used only to detect the second the alarm match begins.
  always_ff @(posedge clk) begin
    prev_time <= current_time;
  end

  always_comb begin
    state_next    = state;
    edit_next     = edit_q;
    digit_next    = edit_digit;
    intended_next = intended_time;
    alarm_next    = alarm_time;
    armed_next    = alarm_armed;
    ring_next     = alarm_ring;
    prop_next     = clock_propagate;
    cnt_next      = cnt;
    case (state)
      RUN: begin
        if (alarm_armed && current_time == alarm_time && current_time != prev_time)
          ring_next = 1'b1;
        if (btn_mode) begin
          state_next = EDIT_CLOCK;
          edit_next  = current_time;
          digit_next = 3'd5;
          ring_next  = 1'b0;
        end else if (btn_confirm) begin
          ring_next = 1'b0;
        end else if (btn_inc && !btn_next) begin
          armed_next = !alarm_armed;
          if (alarm_armed)
            ring_next = 1'b0;
        end
      end
      EDIT_CLOCK, EDIT_ALARM: begin
        if (btn_mode) begin
          if (state == EDIT_CLOCK) begin
            state_next = EDIT_ALARM;
            edit_next  = alarm_time;
            digit_next = 3'd5;
          end else begin
            state_next = RUN;
          end
        end else if (btn_confirm) begin
          if (state == EDIT_CLOCK) begin
            intended_next = edit_q;
            state_next    = PROPAGATE;
            prop_next     = 1'b1;
            cnt_next      = 8'(PROP_CYCLES);
          end else begin
            alarm_next = edit_q;
            armed_next = 1'b1;
            state_next = RUN;
          end
        end else if (btn_next) begin
          digit_next = (edit_digit == 3'd0) ? 3'd5 : edit_digit - 3'd1;
        end else if (btn_inc) begin
          edit_next = inc_digit(edit_q, edit_digit);
        end
      end
      PROPAGATE: begin
        if (cnt <= 8'd1) begin
          prop_next  = 1'b0;
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign mode        = state;
  assign edit_buffer = !rst_n ? 24'h0 : ((state == RUN) ? current_time : edit_q);

endmodule
